// File: rtl/pattern_cascade_pipe.sv
// Cascade of STAGES registered pattern stages with an elastic valid/ready chain,
// per-stage bypass, synchronous flush, occupancy and transfer-count status.
module pattern_cascade_pipe #(
    parameter int STAGES = 2,
    parameter int WIDTH  = 8,
    parameter int CNT_W  = 16,
    localparam int OCC_W = $clog2(STAGES + 1)
) (
    input  logic              blif_clk_net,
    input  logic              blif_reset_net,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  in_data,
    input  logic [STAGES-1:0] bypass,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  out_data,
    output logic [OCC_W-1:0]  occupancy,
    output logic [CNT_W-1:0]  xfer_cnt
);

    function automatic logic [WIDTH-1:0] stage_fn(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] rotl_v;
        logic [WIDTH-1:0] rotr_v;
        rotl_v = {x[WIDTH-2:0], x[WIDTH-1]};
        rotr_v = {x[0], x[WIDTH-1:1]};
        return ~(x & rotl_v) ^ rotr_v;
    endfunction

    logic [WIDTH-1:0]  d_r        [STAGES];
    logic [WIDTH-1:0]  d_nxt_s    [STAGES];
    logic [WIDTH-1:0]  stage_in_s [STAGES];
    logic [STAGES-1:0] v_r;
    logic [STAGES-1:0] v_nxt_s;
    logic [STAGES-1:0] up_v_s;
    logic [STAGES-1:0] cap_s;
    logic [STAGES:0]   rdy_s;
    logic [OCC_W-1:0]  occ_r;
    logic [OCC_W-1:0]  occ_nxt_s;
    logic [CNT_W-1:0]  xfer_r;

    // Ready chain, computed from the output back towards the input.
    always_comb begin
        rdy_s         = '0;
        rdy_s[STAGES] = out_ready;
        for (int s = STAGES - 1; s >= 0; s--) begin
            rdy_s[s] = ~v_r[s] | rdy_s[s+1];
        end
    end

    assign in_ready = rdy_s[0] & ~flush;

    // Per-stage next state; flush beats capture and leaves data registers intact.
    always_comb begin
        stage_in_s[0] = in_data;
        up_v_s        = '0;
        up_v_s[0]     = in_valid & in_ready;
        for (int s = 1; s < STAGES; s++) begin
            stage_in_s[s] = d_r[s-1];
            up_v_s[s]     = v_r[s-1];
        end
        cap_s     = '0;
        v_nxt_s   = v_r;
        occ_nxt_s = '0;
        for (int s = 0; s < STAGES; s++) begin
            d_nxt_s[s] = d_r[s];
            cap_s[s]   = up_v_s[s] & rdy_s[s];
            if (flush) begin
                v_nxt_s[s] = 1'b0;
            end else if (cap_s[s]) begin
                v_nxt_s[s] = 1'b1;
                d_nxt_s[s] = bypass[s] ? stage_in_s[s] : stage_fn(stage_in_s[s]);
            end else if (rdy_s[s+1]) begin
                v_nxt_s[s] = 1'b0;
            end else begin
                v_nxt_s[s] = v_r[s];
            end
            occ_nxt_s = occ_nxt_s + OCC_W'(v_nxt_s[s]);
        end
    end

    // Stage registers and status counters.
    always_ff @(posedge blif_clk_net or negedge blif_reset_net) begin
        if (!blif_reset_net) begin
            for (int s = 0; s < STAGES; s++) begin
                d_r[s] <= '0;
            end
            v_r    <= '0;
            occ_r  <= '0;
            xfer_r <= '0;
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                d_r[s] <= d_nxt_s[s];
            end
            v_r   <= v_nxt_s;
            occ_r <= occ_nxt_s;
            if (v_r[STAGES-1] && out_ready) begin
                xfer_r <= xfer_r + CNT_W'(1);
            end else begin
                xfer_r <= xfer_r;
            end
        end
    end

    assign out_valid = v_r[STAGES-1];
    assign out_data  = d_r[STAGES-1];
    assign occupancy = occ_r;
    assign xfer_cnt  = xfer_r;

endmodule

// File: tb/tb_pattern_cascade_pipe.sv
// Directed, table-driven bench for pattern_cascade_pipe (2 stages, 8 bits, 4-bit counter).
module tb_pattern_cascade_pipe;

    localparam int STAGES = 2;
    localparam int WIDTH  = 8;
    localparam int CNT_W  = 4;
    localparam int OCC_W  = $clog2(STAGES + 1);

    logic              clk;
    logic              rst_n;
    logic              in_valid;
    logic              in_ready;
    logic [WIDTH-1:0]  in_data;
    logic [STAGES-1:0] bypass;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [WIDTH-1:0]  out_data;
    logic [OCC_W-1:0]  occupancy;
    logic [CNT_W-1:0]  xfer_cnt;

    int total = 0;
    int bad   = 0;
    int exp_cnt = 0;

    typedef struct {
        logic [7:0] din;
        logic [1:0] byp;
        logic [7:0] dout;
    } vec_t;

    vec_t vecs [8];

    pattern_cascade_pipe #(.STAGES(STAGES), .WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .blif_clk_net   (clk),
        .blif_reset_net (rst_n),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_data        (in_data),
        .bypass         (bypass),
        .flush          (flush),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_data       (out_data),
        .occupancy      (occupancy),
        .xfer_cnt       (xfer_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic bump_cnt();
        exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
    endtask

    // One word through an idle pipe with out_ready high: visible exactly 2 cycles later.
    task automatic send_one(input logic [7:0] din, input logic [1:0] byp, input logic [7:0] dout);
        @(negedge clk);
        in_valid = 1'b1; in_data = din; bypass = byp; out_ready = 1'b1;
        #1 check("one_in_ready", 64'(in_ready), 64'd1);
        @(negedge clk);
        in_valid = 1'b0;
        check("one_lat1_valid", 64'(out_valid), 64'd0);
        check("one_lat1_occ", 64'(occupancy), 64'd1);
        @(negedge clk);
        check("one_lat2_valid", 64'(out_valid), 64'd1);
        check("one_lat2_data", 64'(out_data), 64'(dout));
        @(negedge clk);
        bump_cnt();
        check("one_drained", 64'(out_valid), 64'd0);
        check("one_xfer", 64'(xfer_cnt), 64'(exp_cnt));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int sent;
        int rcv;
        int first;
        int last;
        bit saw_full;

        vecs[0] = '{8'h01, 2'b00, 8'h3E};
        vecs[1] = '{8'h01, 2'b10, 8'h7F};
        vecs[2] = '{8'h01, 2'b11, 8'h01};
        vecs[3] = '{8'h01, 2'b01, 8'h7F};
        vecs[4] = '{8'h00, 2'b00, 8'hFF};
        vecs[5] = '{8'h80, 2'b00, 8'h1F};
        vecs[6] = '{8'h80, 2'b10, 8'hBF};
        vecs[7] = '{8'hAA, 2'b00, 8'hAA};

        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; bypass = '0;
        flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_out_data", 64'(out_data), 64'd0);
        check("rst_occ", 64'(occupancy), 64'd0);
        check("rst_xfer", 64'(xfer_cnt), 64'd0);
        rst_n = 1'b1;
        #1 check("rst_in_ready", 64'(in_ready), 64'd1);

        for (int i = 0; i < 8; i++) begin
            send_one(vecs[i].din, vecs[i].byp, vecs[i].dout);
        end

        // Stream four words with a downstream stall.
        sent = 0; rcv = 0; first = -1; last = -1; saw_full = 1'b0;
        bypass = 2'b11;
        for (int cyc = 0; cyc < 40 && rcv < 4; cyc++) begin
            @(negedge clk);
            out_ready = (cyc >= 1 && cyc < 5) ? 1'b0 : 1'b1;
            in_valid  = (sent < 4);
            in_data   = 8'(sent + 1);
            #1;
            if (occupancy == 2'd2 && !out_ready) begin
                check("full_in_ready", 64'(in_ready), 64'd0);
                saw_full = 1'b1;
            end
            if (out_valid && out_ready) begin
                check("stream_data", 64'(out_data), 64'(rcv + 1));
                if (first < 0) first = cyc;
                last = cyc;
                rcv++;
                bump_cnt();
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("stream_count", 64'(rcv), 64'd4);
        check("stream_saw_full", 64'(saw_full), 64'd1);
        check("stream_no_gap", 64'(last - first), 64'd3);
        check("stream_xfer", 64'(xfer_cnt), 64'(exp_cnt));

        // Flush a full pipe with downstream stalled.
        in_valid = 1'b1; in_data = 8'h11; bypass = 2'b11; out_ready = 1'b0;
        @(negedge clk);
        in_data = 8'h22;
        @(negedge clk);
        in_valid = 1'b0;
        check("flush_pre_occ", 64'(occupancy), 64'd2);
        flush = 1'b1;
        #1 check("flush_in_ready", 64'(in_ready), 64'd0);
        check("flush_out_valid_held", 64'(out_valid), 64'd1);
        @(negedge clk);
        flush = 1'b0;
        check("flush_occ", 64'(occupancy), 64'd0);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_data_kept", 64'(out_data), 64'h11);
        check("flush_xfer", 64'(xfer_cnt), 64'(exp_cnt));
        #1 check("flush_after_ready", 64'(in_ready), 64'd1);

        // Flush with a simultaneous handshake and input offer.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h44;
        @(negedge clk);
        in_data = 8'h55;
        @(negedge clk);
        in_data = 8'h66; flush = 1'b1; out_ready = 1'b1;
        #1 check("flush2_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk);
        bump_cnt();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        check("flush2_occ", 64'(occupancy), 64'd0);
        check("flush2_data", 64'(out_data), 64'h44);
        check("flush2_xfer", 64'(xfer_cnt), 64'(exp_cnt));

        // Asynchronous reset while out_valid is high.
        @(negedge clk);
        in_valid = 1'b1; in_data = 8'h5A; bypass = 2'b11; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        check("arst_pre_valid", 64'(out_valid), 64'd1);
        check("arst_pre_xfer", 64'(xfer_cnt), 64'(exp_cnt));
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 64'(out_valid), 64'd0);
        check("arst_occ", 64'(occupancy), 64'd0);
        check("arst_xfer", 64'(xfer_cnt), 64'd0);
        check("arst_data", 64'(out_data), 64'd0);
        exp_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        #1 check("arst_in_ready", 64'(in_ready), 64'd1);

        // Counter wrap at 2^CNT_W.
        for (int i = 0; i < 15; i++) begin
            send_one(8'h01, 2'b00, 8'h3E);
        end
        check("wrap_at_max", 64'(xfer_cnt), 64'd15);
        send_one(8'h80, 2'b10, 8'hBF);
        check("wrap_zero", 64'(xfer_cnt), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
